// File: rtl/spram_port_arbiter.sv
// spram_port_arbiter: merges loader, clear engine and CPU onto one single-port RAM port
// with fixed priority loader > clear > CPU, and returns RAM read data to the CPU.
module spram_port_arbiter #(
   parameter int address_width = 10,
   parameter int data_width    = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     load_wr,
   input  logic [address_width-1:0] load_addr,
   input  logic [data_width-1:0]    load_data,
   input  logic                     clear_start,
   input  logic [data_width-1:0]    clear_value,
   input  logic [address_width-1:0] cpu_addr,
   input  logic [data_width-1:0]    cpu_data,
   input  logic                     cpu_wren,
   input  logic                     cpu_rden,
   output logic                     cpu_wait,
   output logic [data_width-1:0]    cpu_q,
   output logic                     cpu_rvalid,
   output logic                     busy,
   output logic                     done,
   output logic [address_width-1:0] ram_address,
   output logic [data_width-1:0]    ram_data,
   output logic                     ram_wren,
   input  logic [data_width-1:0]    ram_q
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                   state_q, state_d;
   logic [address_width-1:0] clear_count_q, clear_count_d;
   logic [data_width-1:0]    fill_q, fill_d;
   logic                     done_q, done_d;
   logic                     rvalid_q, rvalid_d;
   logic                     clearing, clear_grant, last_write, start;
   always_comb begin
      clearing    = state_q == CLEAR;
      clear_grant = clearing & ~load_wr;
      last_write  = clear_grant & (clear_count_q == {address_width{1'b1}});
      start       = ~clearing & clear_start;
      state_d       = start ? CLEAR : last_write ? IDLE : state_q;
      clear_count_d = start ? '0 : clear_grant ? clear_count_q + 1'b1 : clear_count_q;
      fill_d        = start ? clear_value : fill_q;
      done_d        = last_write;
      cpu_wait    = (cpu_wren | cpu_rden) & (load_wr | clearing);
      rvalid_d    = cpu_rden & ~cpu_wait;
      ram_address = load_wr ? load_addr : clearing ? clear_count_q : cpu_addr;
      ram_data    = load_wr ? load_data : clearing ? fill_q : cpu_data;
      ram_wren    = load_wr | clearing | cpu_wren;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         clear_count_q <= '0;
         fill_q        <= '0;
         done_q        <= 1'b0;
         rvalid_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         clear_count_q <= clear_count_d;
         fill_q        <= fill_d;
         done_q        <= done_d;
         rvalid_q      <= rvalid_d;
      end
   end
   assign busy       = state_q == CLEAR;
   assign done       = done_q;
   assign cpu_rvalid = rvalid_q;
   assign cpu_q      = ram_q;
endmodule

// File: tb/tb_spram_port_arbiter.sv
// tb_spram_port_arbiter: directed stimulus against a queue-based model of the arbiter
// plus a behavioural RAM, with literal checks on the test-plan scenarios.
module tb_spram_port_arbiter;
   localparam int AW = 4;
   localparam int DW = 8;
   logic          clock = 1'b0, reset_n = 1'b0;
   logic          load_wr = 0, clear_start = 0, cpu_wren = 0, cpu_rden = 0;
   logic [AW-1:0] load_addr = '0, cpu_addr = '0;
   logic [DW-1:0] load_data = '0, clear_value = '0, cpu_data = '0;
   logic          cpu_wait, cpu_rvalid, busy, done, ram_wren;
   logic [DW-1:0] cpu_q, ram_data, ram_q;
   logic [AW-1:0] ram_address;

   spram_port_arbiter #(.address_width(AW), .data_width(DW)) dut (
      .clock(clock), .reset_n(reset_n), .load_wr(load_wr), .load_addr(load_addr),
      .load_data(load_data), .clear_start(clear_start), .clear_value(clear_value),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
      .cpu_wait(cpu_wait), .cpu_q(cpu_q), .cpu_rvalid(cpu_rvalid), .busy(busy), .done(done),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q));

   always #5 clock = ~clock;

   // Single-port RAM with one-cycle read latency and write-through
   logic [DW-1:0] mem [2**AW];
   always @(posedge clock) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= ram_wren ? ram_data : mem[ram_address];
   end

   // Model: pending clear addresses as a queue, golden memory as an array
   int            pend[$];
   logic [DW-1:0] gm [2**AW];
   logic [DW-1:0] fill_m = '0, e_q = '0;
   logic          e_busy = 0, e_done = 0, e_rv = 0;
   int            nv = 0, ne = 0, cw = 0, cb = 0, cd = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nv++;
      if (act !== exp) begin
         ne++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      fill_m = '0; e_busy = 0; e_done = 0; e_rv = 0;
   endtask

   task automatic model_upd();
      bit wp, gc;
      wp = pend.size() != 0;
      gc = (cpu_wren | cpu_rden) && !load_wr && !wp;
      e_done = 0;
      if (load_wr) gm[load_addr] = load_data;
      else if (wp) begin
         gm[pend[0]] = fill_m;
         void'(pend.pop_front());
         e_done = pend.size() == 0;
      end else if (gc && cpu_wren) gm[cpu_addr] = cpu_data;
      e_rv = gc && cpu_rden;
      if (e_rv) e_q = gm[cpu_addr];
      if (clear_start && !wp) begin
         fill_m = clear_value;
         for (int i = 0; i < 2**AW; i++) pend.push_back(i);
      end
      e_busy = pend.size() != 0;
   endtask

   task automatic compare();
      bit ep;
      logic [AW-1:0] ea;
      ep = pend.size() != 0;
      ea = load_wr ? load_addr : ep ? AW'(pend[0]) : cpu_addr;
      chk("ram_wren", ram_wren, load_wr | ep | cpu_wren);
      chk("ram_address", ram_address, ea);
      if (ram_wren) chk("ram_data", ram_data, load_wr ? load_data : ep ? fill_m : cpu_data);
      chk("cpu_wait", cpu_wait, (cpu_wren | cpu_rden) & (load_wr | ep));
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("cpu_rvalid", cpu_rvalid, e_rv);
      if (e_rv) chk("cpu_q", cpu_q, e_q);
      cw += ram_wren; cb += busy; cd += done;
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clock);
         compare();
         @(posedge clock);
         if (reset_n) model_upd();
         #1;
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load_wr = 1; load_addr = a; load_data = d;
      step();
      load_wr = 0;
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      int n = 0;
      cpu_rden = 1; cpu_addr = a;
      #1;
      while (cpu_wait && n < 200) begin step(); n++; end
      chk("read_timeout", n < 200, 1);
      step();
      chk("read_rvalid", cpu_rvalid, 1);
      d = cpu_q;
      cpu_rden = 0;
   endtask

   task automatic pulse_clear(input logic [DW-1:0] v);
      clear_start = 1; clear_value = v;
      step();
      clear_start = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin step(); n++; end
      chk("done_timeout", n < 100, 1);
      step();
   endtask

   initial begin
      logic [DW-1:0] d;
      int w0, b0, d0, n;
      step(3);
      chk("reset_busy", busy, 0);
      chk("reset_wren", ram_wren, 0);
      reset_n = 1;
      step();
      for (int i = 0; i < 16; i++) load(AW'(i), DW'(8'h10 + i));
      // Reset mid-clear after five writes
      pulse_clear(8'hAA);
      step(5);
      chk("pre_reset_busy", busy, 1);
      reset_n = 0; model_reset();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rvalid", cpu_rvalid, 0);
      step(2);
      reset_n = 1;
      step();
      chk("after_rst_busy", busy, 0);
      for (int i = 0; i < 16; i++) begin
         cpu_read(AW'(i), d);
         chk("partial_clear", d, i < 5 ? 8'hAA : 8'h10 + i);
      end
      // Full clear
      w0 = cw; b0 = cb; d0 = cd;
      pulse_clear(8'h55);
      wait_done();
      chk("full_wren_cycles", cw - w0, 16);
      chk("full_busy_cycles", cb - b0, 16);
      chk("full_done_pulses", cd - d0, 1);
      for (int i = 0; i < 16; i++) begin
         cpu_read(AW'(i), d);
         chk("full_clear", d, 8'h55);
      end
      // Loader preempts the clear after it has passed address 2
      w0 = cw; b0 = cb; d0 = cd;
      pulse_clear(8'h55);
      step(5);
      load_wr = 1; load_addr = 2; load_data = 8'h11;
      step(3);
      load_wr = 0;
      wait_done();
      chk("preempt_wren_cycles", cw - w0, 19);
      chk("preempt_busy_cycles", cb - b0, 19);
      chk("preempt_done_pulses", cd - d0, 1);
      for (int i = 0; i < 16; i++) begin
         cpu_read(AW'(i), d);
         chk("preempt_data", d, i == 2 ? 8'h11 : 8'h55);
      end
      // CPU read stalled by a clear
      load(7, 8'h99);
      pulse_clear(8'h55);
      cpu_rden = 1; cpu_addr = 7;
      #1;
      n = 0;
      while (cpu_wait && n < 100) begin step(); n++; end
      chk("stall_cycles", n, 16);
      chk("stall_busy_at_grant", busy, 0);
      step();
      cpu_rden = 0;
      chk("stall_rvalid", cpu_rvalid, 1);
      chk("stall_q", cpu_q, 8'h55);
      step();
      chk("stall_single_rvalid", cpu_rvalid, 0);
      // CPU write then read
      cpu_wren = 1; cpu_addr = 9; cpu_data = 8'h3C;
      #1;
      chk("wr_wait", cpu_wait, 0);
      step();
      cpu_wren = 0; cpu_rden = 1;
      #1;
      chk("rd_wait", cpu_wait, 0);
      step();
      cpu_rden = 0;
      chk("wr_rd_rvalid", cpu_rvalid, 1);
      chk("wr_rd_q", cpu_q, 8'h3C);
      // Simultaneous write and read is a write with write-through data returned
      cpu_wren = 1; cpu_rden = 1; cpu_addr = 3; cpu_data = 8'h77;
      step();
      cpu_wren = 0; cpu_rden = 0;
      chk("wrrd_rvalid", cpu_rvalid, 1);
      chk("wrrd_q", cpu_q, 8'h77);
      // Second clear_start while busy is ignored
      w0 = cw; d0 = cd;
      pulse_clear(8'h5A);
      step(6);
      clear_start = 1; clear_value = 8'hF0;
      step();
      clear_start = 0;
      wait_done();
      step(20);
      chk("reclear_wren_cycles", cw - w0, 16);
      chk("reclear_done_pulses", cd - d0, 1);
      cpu_read(15, d);
      chk("reclear_fill", d, 8'h5A);
      $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
      $finish;
   end
endmodule

// File: doc/spram_port_arbiter.md
# spram_port_arbiter

Access arbiter and fill engine placed directly upstream of the generic single-port RAM. It merges three write/read sources onto the RAM's single address/data/wren port: the HPS download loader, a hardware clear engine, and the CPU. It also returns the RAM's registered read data to the CPU with a valid strobe. Priority is fixed: loader, then clear, then CPU. The CPU is held off with a wait signal whenever it loses arbitration.

## Interface
- address_width, 10, RAM address bits; clear span is 2**address_width words
- data_width, 8, RAM word width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_wr  in  1  loader write strobe, one word per cycle when high
- load_addr  in  address_width  loader write address
- load_data  in  data_width  loader write data
- clear_start  in  1  one-cycle pulse; starts clearing the whole RAM
- clear_value  in  data_width  fill word; sampled when clear_start is accepted
- cpu_addr  in  address_width  CPU address
- cpu_data  in  data_width  CPU write data
- cpu_wren  in  1  CPU write request, held until not waited
- cpu_rden  in  1  CPU read request, held until not waited
- cpu_wait  out  1  combinational; CPU request not granted this cycle
- cpu_q  out  data_width  CPU read data, meaningful when cpu_rvalid is high
- cpu_rvalid  out  1  registered; high one cycle after a granted CPU read
- busy  out  1  registered; clear engine active
- done  out  1  registered; one-cycle pulse after the last clear write
- ram_address  out  address_width  to RAM address
- ram_data  out  data_width  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  data_width  from RAM q (1-cycle read latency, write-through)

## Operation
- States: IDLE and CLEAR. A clear_count register (address_width bits) and a fill register (data_width bits) hold the clear progress and fill word.
- IDLE, clear_start=1: capture clear_value into fill, set clear_count to 0, set busy=1, go to CLEAR.
- In CLEAR, clear_start is ignored. In IDLE, clear_start coincident with load_wr is still accepted.
- Grant per cycle is combinational and evaluated in priority order:
  - load_wr=1: drive ram_address=load_addr, ram_data=load_data, ram_wren=1.
  - else if state is CLEAR: drive ram_address=clear_count, ram_data=fill, ram_wren=1.
  - else if cpu_wren or cpu_rden: drive ram_address=cpu_addr and ram_data=cpu_data. ram_wren=cpu_wren.
  - else: ram_wren=0 and ram_address=cpu_addr.
- If cpu_wren and cpu_rden are both high, the access is a write; cpu_rvalid still pulses, and cpu_q returns the written data (RAM write-through).
- cpu_wait = (cpu_wren | cpu_rden) & (load_wr | state==CLEAR).
- Clear advance: clear_count increments only in cycles where CLEAR holds the port (no load_wr). A loader write stalls the clear engine; it does not skip an address.
- Clear completion: on the granted write at clear_count = 2**address_width-1:
  - next state is IDLE, busy=0, done=1 for one cycle;
  - clear_count wraps to 0.
- cpu_rvalid <= cpu_rden & ~cpu_wait. cpu_q = ram_q (passthrough); it is valid in the cycle cpu_rvalid is high.
- Reset (asynchronous, at any time, including mid-clear):
  - state IDLE, clear_count 0, fill 0, busy 0, done 0, cpu_rvalid 0.
  - ram_wren follows the inputs combinationally, so it is 0 when no request is present.
  - A partial clear is abandoned and is not resumed.

## Timing
- Loader and CPU writes reach the RAM in the same cycle they are presented; there are no pipeline registers on the RAM-side outputs.
- CPU read latency is 1 cycle from the granted request to cpu_rvalid/cpu_q.
- A full uninterrupted clear takes exactly 2**address_width cycles of ram_wren, starting the cycle after clear_start.
  - busy rises in the cycle after clear_start and falls in the cycle after the last clear write.
  - done pulses in that same cycle.
- Each load_wr cycle during CLEAR extends the clear by exactly one cycle.
- cpu_wait can change every cycle. The CPU must hold its address, data and request stable while cpu_wait=1.
- There is no combinational path from ram_q to any output except cpu_q.

## Test plan
- Reset mid-clear: address_width=4, start clear with clear_value=8'hAA, assert reset_n=0 after 5 writes, then release.
  - Expected: busy=0, done=0, cpu_rvalid=0 immediately on reset.
  - Expected: addresses 0-4 read 8'hAA and addresses 5-15 hold their prior contents.
- Full clear: address_width=4, clear_value=8'h55.
  - Expected: exactly 16 consecutive ram_wren cycles at addresses 0..15, busy high for 16 cycles, done pulse once.
  - Expected: CPU reads of addresses 0..15 afterwards all return 8'h55.
- Loader preempting clear: 3 load_wr cycles (addr 2, data 8'h11) injected mid-clear.
  - Expected: clear lasts 19 cycles with no address skipped.
  - Expected: address 2 holds 8'h55 if the loader write came before the clear reached it, 8'h11 if after.
- CPU stall: cpu_rden held at addr 7 during a clear.
  - Expected: cpu_wait=1 until busy drops, then a single cpu_rvalid with cpu_q=8'h55.
- CPU write then read: write 8'h3C to addr 9, then read addr 9 in the next cycle.
  - Expected: cpu_wait=0 in both cycles; cpu_rvalid in the following cycle with cpu_q=8'h3C.
- clear_start while busy: second pulse sent mid-clear.
  - Expected: it is ignored; one done pulse, 16 clear writes total.
